// File: rtl/seq_sched_pkg.sv
// Shared types and defaults for the time-shared "110011" sequence detector.
// The optional per-channel hit counters are enabled by the macro SEQ_SCHED_HIT_CNT_EN.
package seq_sched_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    FLUSH = 2'd2
  } state_t;

  localparam int                           DEFAULT_PAT_LEN = 6;
  localparam logic [DEFAULT_PAT_LEN-1:0]   DEFAULT_PATTERN = 6'b110011;

endpackage

// File: rtl/seq_rr_arbiter.sv
// Combinational round-robin arbiter: grants the first requester at or after ptr,
// wrapping from N_CH-1 back to 0.
module seq_rr_arbiter
  import seq_sched_pkg::*;
#(
  parameter  int N_CH  = 4,
  localparam int IDX_W = $clog2(N_CH)
) (
  input  logic [N_CH-1:0]  req,
  input  logic [IDX_W-1:0] ptr,
  output logic [N_CH-1:0]  gnt,
  output logic [IDX_W-1:0] gnt_idx,
  output logic             any_gnt
);

  localparam int                 SUM_W  = IDX_W + 1;
  localparam logic [SUM_W-1:0]   N_CH_S = SUM_W'(N_CH);

  logic [SUM_W-1:0] sum;

  // NOTE: every output of a combinational block gets a default before any
  // conditional assignment; otherwise synthesis infers a latch to hold it.
  always_comb begin
    gnt     = '0;
    gnt_idx = '0;
    any_gnt = 1'b0;
    sum     = '0;
    for (int k = 0; k < N_CH; k++) begin
      sum = {1'b0, ptr} + SUM_W'(k);
      if (sum >= N_CH_S) sum = sum - N_CH_S;
      if (!any_gnt && req[sum[IDX_W-1:0]]) begin
        any_gnt                 = 1'b1;
        gnt[sum[IDX_W-1:0]]     = 1'b1;
        gnt_idx                 = sum[IDX_W-1:0];
      end
    end
  end

endmodule

// File: rtl/seq_detect_tdm_scheduler.sv
// One bit-serial pattern detector shared by N_CH channels under round-robin grants.
// Define SEQ_SCHED_HIT_CNT_EN to add saturating per-channel hit counters (hit_cnt port).
module seq_detect_tdm_scheduler
  import seq_sched_pkg::*;
#(
  parameter int                 N_CH    = 4,
  parameter int                 PAT_LEN = DEFAULT_PAT_LEN,
  parameter logic [PAT_LEN-1:0] PATTERN = DEFAULT_PATTERN
`ifdef SEQ_SCHED_HIT_CNT_EN
  , parameter int               CNT_W   = 8
`endif
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     en,
  input  logic                     clear,
  input  logic [N_CH-1:0]          req,
  input  logic [N_CH-1:0]          bit_in,
  output logic [N_CH-1:0]          gnt,
  output logic                     det,
  output logic [$clog2(N_CH)-1:0]  det_ch
`ifdef SEQ_SCHED_HIT_CNT_EN
  , output logic [N_CH*CNT_W-1:0]  hit_cnt
`endif
);

  localparam int                IDX_W    = $clog2(N_CH);
  localparam int                FILL_W   = $clog2(PAT_LEN);
  localparam logic [FILL_W-1:0] FILL_MAX = FILL_W'(PAT_LEN - 1);
  localparam logic [IDX_W-1:0]  LAST_CH  = IDX_W'(N_CH - 1);

  state_t                 state;
  logic [IDX_W-1:0]       ptr;
  logic [PAT_LEN-2:0]     hist [N_CH];
  logic [FILL_W-1:0]      fill [N_CH];

  logic [N_CH-1:0]        arb_gnt;
  logic [IDX_W-1:0]       gnt_idx;
  logic                   any_gnt;
  logic                   active;
  logic                   accept;
  logic                   match;
  logic [PAT_LEN-1:0]     window;
  logic [IDX_W-1:0]       next_ptr;

  seq_rr_arbiter #(.N_CH(N_CH)) u_arb (
    .req     (req),
    .ptr     (ptr),
    .gnt     (arb_gnt),
    .gnt_idx (gnt_idx),
    .any_gnt (any_gnt)
  );

  // Grants only while running, enabled and not being cleared.
  assign active   = (state == RUN) && en && !clear;
  assign gnt      = active ? arb_gnt : '0;
  assign accept   = active && any_gnt;
  assign window   = {hist[gnt_idx], bit_in[gnt_idx]};
  assign match    = accept && (fill[gnt_idx] == FILL_MAX) && (window == PATTERN);
  assign next_ptr = (gnt_idx == LAST_CH) ? '0 : gnt_idx + 1'b1;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state  <= IDLE;
      ptr    <= '0;
      det    <= 1'b0;
      det_ch <= '0;
      // NOTE: the history arrays are small flop banks, not RAM, so they take the
      // async reset; that is what discards partial matches on reset.
      for (int i = 0; i < N_CH; i++) begin
        hist[i] <= '0;
        fill[i] <= '0;
      end
    end else begin
      det <= match;
      if (match) det_ch <= gnt_idx;

      if (clear) begin
        state <= FLUSH;
        for (int i = 0; i < N_CH; i++) begin
          hist[i] <= '0;
          fill[i] <= '0;
        end
      end else begin
        case (state)
          IDLE:    if (en && |req)    state <= RUN;
          RUN:     if (!en || !(|req)) state <= IDLE;
          FLUSH:   state <= IDLE;
          default: state <= IDLE;
        endcase

        if (accept) begin
          ptr           <= next_ptr;
          hist[gnt_idx] <= window[PAT_LEN-2:0];
          if (fill[gnt_idx] != FILL_MAX) fill[gnt_idx] <= fill[gnt_idx] + 1'b1;
        end
      end
    end
  end

`ifdef SEQ_SCHED_HIT_CNT_EN
  logic [CNT_W-1:0] cnt [N_CH];

  // Counters step on the same edge that raises det, saturating at all-ones.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < N_CH; i++) cnt[i] <= '0;
    end else if (clear) begin
      for (int i = 0; i < N_CH; i++) cnt[i] <= '0;
    end else if (match && (cnt[gnt_idx] != '1)) begin
      cnt[gnt_idx] <= cnt[gnt_idx] + 1'b1;
    end
  end

  always_comb begin
    hit_cnt = '0;
    for (int i = 0; i < N_CH; i++) hit_cnt[i*CNT_W +: CNT_W] = cnt[i];
  end
`endif

endmodule
